auto_player: RTL and testbench
==============================

Name: auto_player

Overview:
- Automated opponent that drives the game core's per-cell button inputs, acting as the second player.
- Watches board occupancy, turn and game-over flags from the game core.
- On its turn it scans all eight lines, chooses a move by fixed priority, issues a timed one-hot button press, then waits for the cell to show as occupied.
- Sits between the board logic and the physical button mux; a select outside this block picks between human buttons and this block's outputs.

Parameters:
- PRESS_CYCLES, 4: clock cycles a button is held high; range 1..15.
- ACK_TIMEOUT, 16: cycles to wait after release for the chosen cell to read as own-occupied; range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  auto-play permitted.
- my_turn  input  1  high when it is this player's turn (player-2 profile).
- game_over  input  1  OR of p1_win, p2_win and grid_full.
- own_cells  input  9  cells held by this player.
- opp_cells  input  9  cells held by the opponent.
- btn  output  9  one-hot button press, registered.
- busy  output  1  high in any state other than IDLE.
- move_idx  output  4  last chosen cell, 0..8.
- error  output  1  sticky fault flag; cleared only by reset.

Cell bit order: bit0..bit8 = a,b,c,d,e,f,g,h,i, row-major (a b c / d e f / g h i).

Behaviour:
- Reset (asynchronous, while reset=0): state=IDLE, btn=0, busy=0, move_idx=0, error=0, snapshot and candidate registers cleared.
- IDLE:
  - btn=0.
  - If enable & my_turn & ~game_over at a clock edge: latch own_cells/opp_cells into the snapshot, clear both candidates, line counter=0, go to SCAN.
- SCAN:
  - 8 cycles, one line per cycle, evaluated on the snapshot only.
  - Line order: 0=abc, 1=def, 2=ghi, 3=adg, 4=beh, 5=cfi, 6=aei, 7=ceg.
  - Two own cells plus one empty cell: record the empty cell as the win candidate, only if none is recorded yet.
  - Two opponent cells plus one empty cell: record the empty cell as the block candidate, only if none is recorded yet.
  - After line 7, go to DECIDE.
- DECIDE (1 cycle):
  - Priority: win candidate > block candidate > e if empty > first empty corner in order a,c,g,i > first empty edge in order b,d,f,h.
  - Latch the result into move_idx and go to PRESS.
  - If no empty cell exists: set error, go to IDLE.
- PRESS:
  - btn[move_idx]=1 and all other bits 0, for exactly PRESS_CYCLES cycles.
  - Then go to WAIT_ACK with btn=0.
- WAIT_ACK:
  - If own_cells[move_idx]=1 (live input): go to WAIT_TURN.
  - If ACK_TIMEOUT cycles elapse without it: set error, go to IDLE.
  - If opp_cells[move_idx]=1 (live input): set error, go to IDLE.
- WAIT_TURN:
  - Stay until my_turn=0, then go to IDLE.
  - This prevents a second move within the same turn.
- Abort:
  - In any state except IDLE, if game_over=1 or enable=0 at an edge: go to IDLE.
  - btn=0 from that edge onward, and any partial press is truncated.
  - error is not set on abort.
- Latency:
  - Trigger sampled at edge T: SCAN covers T+1..T+8, DECIDE is T+9.
  - btn rises at edge T+10 and falls at edge T+10+PRESS_CYCLES.
- Board changes during SCAN/DECIDE are ignored because decisions use the snapshot.
- btn is never multi-hot.
- btn is never asserted on a cell that is non-empty in the snapshot.

Test Plan:
- Reset low mid-PRESS → btn=0, busy=0, error=0 immediately, without waiting for a clock; after release with my_turn=1 and enable=1, a full new sequence starts.
- Empty board, my_turn rises → btn=9'h010 (cell e) from T+10 for 4 cycles; set own_cells[4]=1 during WAIT_ACK → WAIT_TURN; drop my_turn → busy=0.
- Win beats block: own=a,b (9'h003), opp=d,e (9'h018) → move_idx=2 (c), btn=9'h004.
- Block: own=e (9'h010), opp=a,b (9'h003) → move_idx=2 (c).
- Corner/edge fallback: own=0, opp=e (9'h010) → move_idx=0 (a); full board with only f empty and no lines open → move_idx=5.
- Never acknowledged: ACK_TIMEOUT=16, own_cells never sets → error=1 at 16 cycles after btn falls, state IDLE; game_over raised during SCAN → IDLE next edge, btn stays 0, error unchanged.

Source files
------------

// File: rtl/auto_player.sv
// Automated second player: snapshots the board on its turn, scans the eight lines,
// picks a move by fixed priority and drives a timed one-hot button press.
module auto_player #(
    parameter int unsigned PRESS_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       my_turn,
    input  logic       game_over,
    input  logic [8:0] own_cells,
    input  logic [8:0] opp_cells,
    output logic [8:0] btn,
    output logic       busy,
    output logic [3:0] move_idx,
    output logic       error
);

    localparam int unsigned N_CELLS = 9;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned LINE_W  = 3;
    localparam int unsigned CNT_W   = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SCAN      = 3'd1;
    localparam logic [2:0] ST_DECIDE    = 3'd2;
    localparam logic [2:0] ST_PRESS     = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd4;
    localparam logic [2:0] ST_WAIT_TURN = 3'd5;

    logic [2:0]         state, state_nxt;
    logic [N_CELLS-1:0] snap_own, snap_own_nxt;
    logic [N_CELLS-1:0] snap_opp, snap_opp_nxt;
    logic               win_vld, win_vld_nxt;
    logic [IDX_W-1:0]   win_idx, win_idx_nxt;
    logic               blk_vld, blk_vld_nxt;
    logic [IDX_W-1:0]   blk_idx, blk_idx_nxt;
    logic [LINE_W-1:0]  line_cnt, line_cnt_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [N_CELLS-1:0] btn_nxt;
    logic               busy_nxt;
    logic [IDX_W-1:0]   move_nxt;
    logic               error_nxt;

    // Cell indices of each line, packed {c2, c1, c0}.
    function automatic logic [3*IDX_W-1:0] line_cells(input logic [LINE_W-1:0] l);
        case (l)
            3'd0:    line_cells = {4'd2, 4'd1, 4'd0};
            3'd1:    line_cells = {4'd5, 4'd4, 4'd3};
            3'd2:    line_cells = {4'd8, 4'd7, 4'd6};
            3'd3:    line_cells = {4'd6, 4'd3, 4'd0};
            3'd4:    line_cells = {4'd7, 4'd4, 4'd1};
            3'd5:    line_cells = {4'd8, 4'd5, 4'd2};
            3'd6:    line_cells = {4'd8, 4'd4, 4'd0};
            default: line_cells = {4'd6, 4'd4, 4'd2};
        endcase
    endfunction

    logic [3*IDX_W-1:0] cells;
    logic [IDX_W-1:0]   c0, c1, c2, empty_idx;
    logic [1:0]         own_n, opp_n;
    logic               line_win, line_blk;
    logic [N_CELLS-1:0] empties;
    logic               dec_vld;
    logic [IDX_W-1:0]   dec_idx;

    // Current line evaluation against the snapshot.
    always_comb begin
        cells = line_cells(line_cnt);
        c0    = cells[IDX_W-1:0];
        c1    = cells[2*IDX_W-1:IDX_W];
        c2    = cells[3*IDX_W-1:2*IDX_W];
        own_n = {1'b0, snap_own[c0]} + {1'b0, snap_own[c1]} + {1'b0, snap_own[c2]};
        opp_n = {1'b0, snap_opp[c0]} + {1'b0, snap_opp[c1]} + {1'b0, snap_opp[c2]};
        if (!snap_own[c0] && !snap_opp[c0])      empty_idx = c0;
        else if (!snap_own[c1] && !snap_opp[c1]) empty_idx = c1;
        else                                     empty_idx = c2;
        line_win = (own_n == 2'd2) && (opp_n == 2'd0);
        line_blk = (opp_n == 2'd2) && (own_n == 2'd0);
    end

    // Move priority: win, block, centre, corners a c g i, edges b d f h.
    always_comb begin
        empties = ~(snap_own | snap_opp);
        dec_vld = 1'b1;
        dec_idx = '0;
        if (win_vld)         dec_idx = win_idx;
        else if (blk_vld)    dec_idx = blk_idx;
        else if (empties[4]) dec_idx = 4'd4;
        else if (empties[0]) dec_idx = 4'd0;
        else if (empties[2]) dec_idx = 4'd2;
        else if (empties[6]) dec_idx = 4'd6;
        else if (empties[8]) dec_idx = 4'd8;
        else if (empties[1]) dec_idx = 4'd1;
        else if (empties[3]) dec_idx = 4'd3;
        else if (empties[5]) dec_idx = 4'd5;
        else if (empties[7]) dec_idx = 4'd7;
        else                 dec_vld = 1'b0;
    end

    always_comb begin
        state_nxt    = state;
        snap_own_nxt = snap_own;
        snap_opp_nxt = snap_opp;
        win_vld_nxt  = win_vld;
        win_idx_nxt  = win_idx;
        blk_vld_nxt  = blk_vld;
        blk_idx_nxt  = blk_idx;
        line_cnt_nxt = line_cnt;
        cnt_nxt      = cnt;
        btn_nxt      = '0;
        move_nxt     = move_idx;
        error_nxt    = error;

        case (state)
            ST_IDLE: begin
                if (enable && my_turn && !game_over) begin
                    snap_own_nxt = own_cells;
                    snap_opp_nxt = opp_cells;
                    win_vld_nxt  = 1'b0;
                    win_idx_nxt  = '0;
                    blk_vld_nxt  = 1'b0;
                    blk_idx_nxt  = '0;
                    line_cnt_nxt = '0;
                    state_nxt    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (line_win && !win_vld) begin
                    win_vld_nxt = 1'b1;
                    win_idx_nxt = empty_idx;
                end
                if (line_blk && !blk_vld) begin
                    blk_vld_nxt = 1'b1;
                    blk_idx_nxt = empty_idx;
                end
                line_cnt_nxt = line_cnt + 3'd1;
                if (line_cnt == 3'd7) state_nxt = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (dec_vld) begin
                    move_nxt  = dec_idx;
                    cnt_nxt   = '0;
                    state_nxt = ST_PRESS;
                end else begin
                    error_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_PRESS: begin
                if (cnt < CNT_W'(PRESS_CYCLES)) begin
                    btn_nxt = N_CELLS'(1) << move_idx;
                    cnt_nxt = cnt + 8'd1;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (own_cells[move_idx]) begin
                    state_nxt = ST_WAIT_TURN;
                end else if (opp_cells[move_idx] || (cnt == CNT_W'(ACK_TIMEOUT - 1))) begin
                    error_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_WAIT_TURN: begin
                if (!my_turn) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort wins over everything and never raises error.
        if ((state != ST_IDLE) && (game_over || !enable)) begin
            state_nxt = ST_IDLE;
            btn_nxt   = '0;
            error_nxt = error;
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            snap_own <= '0;
            snap_opp <= '0;
            win_vld  <= 1'b0;
            win_idx  <= '0;
            blk_vld  <= 1'b0;
            blk_idx  <= '0;
            line_cnt <= '0;
            cnt      <= '0;
            btn      <= '0;
            busy     <= 1'b0;
            move_idx <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            snap_own <= snap_own_nxt;
            snap_opp <= snap_opp_nxt;
            win_vld  <= win_vld_nxt;
            win_idx  <= win_idx_nxt;
            blk_vld  <= blk_vld_nxt;
            blk_idx  <= blk_idx_nxt;
            line_cnt <= line_cnt_nxt;
            cnt      <= cnt_nxt;
            btn      <= btn_nxt;
            busy     <= busy_nxt;
            move_idx <= move_nxt;
            error    <= error_nxt;
        end
    end

endmodule

// File: tb/tb_auto_player.sv
// Directed self-checking bench for auto_player; inputs driven and outputs sampled on negedge.
module tb_auto_player;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       my_turn;
    logic       game_over;
    logic [8:0] own_cells;
    logic [8:0] opp_cells;
    logic [8:0] btn;
    logic       busy;
    logic [3:0] move_idx;
    logic       error;

    int errors = 0;
    int checks = 0;

    auto_player #(.PRESS_CYCLES(4), .ACK_TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .my_turn   (my_turn),
        .game_over (game_over),
        .own_cells (own_cells),
        .opp_cells (opp_cells),
        .btn       (btn),
        .busy      (busy),
        .move_idx  (move_idx),
        .error     (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; the following posedge is trigger edge T.
    task automatic start_turn(input logic [8:0] own, input logic [8:0] opp);
        own_cells = own;
        opp_cells = opp;
        my_turn   = 1'b1;
    endtask

    // Called after btn has fallen: acknowledge, end the turn, expect idle.
    task automatic finish_turn(input logic [3:0] idx);
        own_cells[idx] = 1'b1;
        step(1);
        my_turn = 1'b0;
        step(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL finish_turn_busy: got %b expected 0", busy);
        end
        own_cells = '0;
        opp_cells = '0;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({btn, busy, move_idx, error} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: btn=%h busy=%b move=%0d err=%b expected all 0",
                     btn, busy, move_idx, error);
        end
        @(negedge clk);
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_empty_board;
        start_turn(9'h000, 9'h000);
        step(1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy_scan: got %b expected 1", busy); end
        step(9);
        checks++;
        if (btn !== 9'h000) begin errors++; $display("FAIL empty_btn_before: got %h expected 000", btn); end
        step(1);
        checks++;
        if (btn !== 9'h010) begin errors++; $display("FAIL empty_btn_rise: got %h expected 010", btn); end
        checks++;
        if (move_idx !== 4'd4) begin errors++; $display("FAIL empty_move: got %0d expected 4", move_idx); end
        step(3);
        checks++;
        if (btn !== 9'h010) begin errors++; $display("FAIL empty_btn_hold: got %h expected 010", btn); end
        step(1);
        checks++;
        if (btn !== 9'h000) begin errors++; $display("FAIL empty_btn_fall: got %h expected 000", btn); end
        own_cells = 9'h010;
        step(4);
        checks++;
        if ({busy, btn} !== {1'b1, 9'h000}) begin
            errors++;
            $display("FAIL empty_wait_turn: busy=%b btn=%h expected busy=1 btn=000", busy, btn);
        end
        my_turn = 1'b0;
        step(1);
        checks++;
        if ({busy, error} !== 2'b00) begin
            errors++;
            $display("FAIL empty_idle: busy=%b err=%b expected 0 0", busy, error);
        end
        own_cells = '0;
        step(1);
    endtask

    // Board disturbed during SCAN must not affect the snapshot-based decision.
    task automatic test_win_over_block;
        start_turn(9'h003, 9'h018);
        step(2);
        own_cells = 9'h000;
        step(6);
        own_cells = 9'h003;
        step(3);
        checks++;
        if (move_idx !== 4'd2) begin errors++; $display("FAIL win_move: got %0d expected 2", move_idx); end
        checks++;
        if (btn !== 9'h004) begin errors++; $display("FAIL win_btn: got %h expected 004", btn); end
        step(4);
        finish_turn(4'd2);
    endtask

    task automatic test_block;
        start_turn(9'h010, 9'h003);
        step(11);
        checks++;
        if (move_idx !== 4'd2) begin errors++; $display("FAIL block_move: got %0d expected 2", move_idx); end
        checks++;
        if (btn !== 9'h004) begin errors++; $display("FAIL block_btn: got %h expected 004", btn); end
        step(4);
        finish_turn(4'd2);
    endtask

    task automatic test_fallback;
        start_turn(9'h000, 9'h010);
        step(11);
        checks++;
        if ({move_idx, btn} !== {4'd0, 9'h001}) begin
            errors++;
            $display("FAIL corner_move: move=%0d btn=%h expected move=0 btn=001", move_idx, btn);
        end
        step(4);
        finish_turn(4'd0);
        start_turn(9'h189, 9'h056);
        step(11);
        checks++;
        if ({move_idx, btn} !== {4'd5, 9'h020}) begin
            errors++;
            $display("FAIL edge_move: move=%0d btn=%h expected move=5 btn=020", move_idx, btn);
        end
        step(4);
        finish_turn(4'd5);
    endtask

    task automatic test_game_over;
        start_turn(9'h000, 9'h000);
        step(4);
        game_over = 1'b1;
        step(1);
        checks++;
        if ({busy, btn, error} !== 11'd0) begin
            errors++;
            $display("FAIL gameover_abort: busy=%b btn=%h err=%b expected 0 000 0", busy, btn, error);
        end
        step(8);
        checks++;
        if ({busy, btn} !== 10'd0) begin
            errors++;
            $display("FAIL gameover_quiet: busy=%b btn=%h expected 0 000", busy, btn);
        end
        game_over = 1'b0;
        my_turn   = 1'b0;
        step(1);
    endtask

    task automatic test_timeout;
        start_turn(9'h000, 9'h000);
        step(11);
        checks++;
        if (btn !== 9'h010) begin errors++; $display("FAIL timeout_btn: got %h expected 010", btn); end
        step(4);
        step(15);
        checks++;
        if ({error, busy} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_early: err=%b busy=%b expected err=0 busy=1", error, busy);
        end
        step(1);
        checks++;
        if ({error, busy} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_fire: err=%b busy=%b expected err=1 busy=0", error, busy);
        end
        my_turn = 1'b0;
        step(2);
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", error); end
    endtask

    task automatic test_reset_mid_press;
        start_turn(9'h000, 9'h000);
        step(12);
        checks++;
        if (btn !== 9'h010) begin errors++; $display("FAIL midpress_btn: got %h expected 010", btn); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({btn, busy, error, move_idx} !== 15'd0) begin
            errors++;
            $display("FAIL midpress_async: btn=%h busy=%b err=%b move=%0d expected all 0",
                     btn, busy, error, move_idx);
        end
        @(negedge clk);
        reset = 1'b1;
        step(11);
        checks++;
        if ({move_idx, btn} !== {4'd4, 9'h010}) begin
            errors++;
            $display("FAIL midpress_restart: move=%0d btn=%h expected move=4 btn=010", move_idx, btn);
        end
        step(4);
        finish_turn(4'd4);
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        my_turn   = 1'b0;
        game_over = 1'b0;
        own_cells = '0;
        opp_cells = '0;
        test_reset;
        test_empty_board;
        test_win_over_block;
        test_block;
        test_fallback;
        test_game_over;
        test_timeout;
        test_reset_mid_press;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
